multicycle_control_unit: RTL

Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH / DECODE / EXECUTE / MEM / WRITEBACK states and drives the same `signal_*` datapath controls per state, plus PC, IR and PC-source controls. It waits on a memory ready handshake and bounds each wait with a timeout. Opcode width is a parameter, and any opcode outside the four defined classes is trapped as illegal.

---
 rtl/multicycle_control_unit_if.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multi-cycle sequencer and its datapath/memory side.
interface multicycle_control_unit_if #(
    parameter int OPCODE_WIDTH = 2
);
    logic                    start;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic                    mem_ready;
    logic                    clear;

    logic                    signal_regdst;
    logic                    signal_regwrite;
    logic                    signal_alusrc;
    logic                    signal_branch;
    logic                    signal_memread;
    logic                    signal_memwrite;
    logic                    signal_memtoreg;
    logic                    signal_aluop;
    logic                    signal_pcwrite;
    logic                    signal_irwrite;
    logic                    signal_pcsrc;

    logic                    busy;
    logic                    done;
    logic [1:0]              fault_code;
    logic [2:0]              state;

    modport master (
        output start, opcode, zero, mem_ready, clear,
        input  signal_regdst, signal_regwrite, signal_alusrc, signal_branch,
               signal_memread, signal_memwrite, signal_memtoreg, signal_aluop,
               signal_pcwrite, signal_irwrite, signal_pcsrc,
               busy, done, fault_code, state
    );

    modport slave (
        input  start, opcode, zero, mem_ready, clear,
        output signal_regdst, signal_regwrite, signal_alusrc, signal_branch,
               signal_memread, signal_memwrite, signal_memtoreg, signal_aluop,
               signal_pcwrite, signal_irwrite, signal_pcsrc,
               busy, done, fault_code, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with bounded
// memory waits and illegal-opcode / timeout trapping into a sticky FAULT state.
module multicycle_control_unit #(
    parameter int OPCODE_WIDTH = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input logic                       clock,
    input logic                       reset_n,
    multicycle_control_unit_if.slave  bus
);

    localparam int CNT_RAW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int CNT_W   = (CNT_RAW > 1) ? CNT_RAW : 1;
    localparam logic [CNT_W:0] TO_V = (CNT_W + 1)'(MEM_TIMEOUT);

    localparam logic [1:0] OP_R  = 2'd0;
    localparam logic [1:0] OP_LD = 2'd1;
    localparam logic [1:0] OP_ST = 2'd2;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       opcode_q, opcode_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             timeout_hit;
    logic             illegal_op;
    logic             complete;

    logic regdst, regwrite, alusrc, branch, memread, memwrite, memtoreg, aluop;
    logic pcwrite, irwrite, pcsrc, done;

    // Codes above 3 are illegal; with a 2-bit opcode every code is a legal class.
    if (OPCODE_WIDTH > 2) begin : g_wide_opcode
        assign illegal_op = |bus.opcode[OPCODE_WIDTH-1:2];
    end else begin : g_narrow_opcode
        assign illegal_op = 1'b0;
    end

    assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc >= TO_V);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            opcode_q <= 2'd0;
            fault_q  <= FC_NONE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        fault_d  = fault_q;
        complete = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        branch   = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        aluop    = 1'b0;
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        pcsrc    = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                memread = 1'b1;
                if (bus.mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                    fault_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                opcode_d = bus.opcode[1:0];
                if (illegal_op) begin
                    state_d = S_FAULT;
                    fault_d = FC_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (opcode_q)
                    OP_R: begin
                        aluop   = 1'b1;
                        state_d = S_WRITEBACK;
                    end
                    OP_LD, OP_ST: begin
                        alusrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        branch   = 1'b1;
                        pcwrite  = bus.zero;
                        pcsrc    = bus.zero;
                        complete = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                alusrc = 1'b1;
                if (opcode_q == OP_ST) memwrite = 1'b1;
                else                   memread  = 1'b1;
                if (bus.mem_ready) begin
                    if (opcode_q == OP_ST) complete = 1'b1;
                    else                   state_d  = S_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                    fault_d = FC_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                regwrite = 1'b1;
                regdst   = (opcode_q == OP_R);
                memtoreg = (opcode_q == OP_LD);
                complete = 1'b1;
            end
            S_FAULT: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                    fault_d = FC_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A start seen in the completing cycle issues the next fetch with no idle gap.
        if (complete) begin
            done    = 1'b1;
            state_d = bus.start ? S_FETCH : S_IDLE;
        end
    end

    // The wait counter restarts whenever FETCH or MEM is (re)entered and saturates at all-ones.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
            cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
        end
    end

    assign bus.signal_regdst   = regdst;
    assign bus.signal_regwrite = regwrite;
    assign bus.signal_alusrc   = alusrc;
    assign bus.signal_branch   = branch;
    assign bus.signal_memread  = memread;
    assign bus.signal_memwrite = memwrite;
    assign bus.signal_memtoreg = memtoreg;
    assign bus.signal_aluop    = aluop;
    assign bus.signal_pcwrite  = pcwrite;
    assign bus.signal_irwrite  = irwrite;
    assign bus.signal_pcsrc    = pcsrc;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = done;
    assign bus.fault_code      = fault_q;
    assign bus.state           = state_q;

endmodule
